sw_debounce_sync: RTL and testbench

SW_DEBOUNCE_SYNC -- requirements
Module: sw_debounce_sync

---
 rtl/sw_debounce_sync.sv | 69 ++++++
 tb/tb_sw_debounce_sync.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_sync.sv
// Multi-channel switch debouncer: two-flop synchronizer, per-channel stability counter,
// registered rise/fall pulses and a push-on/push-off toggle per channel.
module sw_debounce_sync #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  i_sw,
  input  logic [CNT_W-1:0] i_db_th,
  output logic [N_CH-1:0]  o_sw_level,
  output logic [N_CH-1:0]  o_rise,
  output logic [N_CH-1:0]  o_fall,
  output logic [N_CH-1:0]  o_sw_toggle
);

  // Flip point is eff_th-1; a zero threshold behaves like a threshold of one.
  logic [CNT_W-1:0] th_m1;

  always_comb begin
    th_m1 = '0;
    if (i_db_th != '0) th_m1 = i_db_th - CNT_W'(1);
  end

  for (genvar n = 0; n < N_CH; n++) begin : g_ch
    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             rise;
    logic             fall;
    logic             tog;
    logic [CNT_W-1:0] cnt;

    // Counter clears on agreement and never wraps: >= forces the flip at the limit.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        stable <= 1'b0;
        cnt    <= '0;
        rise   <= 1'b0;
        fall   <= 1'b0;
        tog    <= 1'b0;
      end else begin
        sync1 <= i_sw[n];
        sync2 <= sync1;
        rise  <= 1'b0;
        fall  <= 1'b0;
        if (sync2 == stable) begin
          cnt <= '0;
        end else if (cnt >= th_m1) begin
          stable <= sync2;
          cnt    <= '0;
          rise   <= sync2;
          fall   <= ~sync2;
          if (sync2) tog <= ~tog;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign o_sw_level[n]  = stable;
    assign o_rise[n]      = rise;
    assign o_fall[n]      = fall;
    assign o_sw_toggle[n] = tog;
  end

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync: each step queues the expected per-cycle outputs,
// then clocks the design and checks every cycle against the queue.
module tb_sw_debounce_sync;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 32;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [N_CH-1:0]  i_sw;
  logic [CNT_W-1:0] i_db_th;
  logic [N_CH-1:0]  o_sw_level;
  logic [N_CH-1:0]  o_rise;
  logic [N_CH-1:0]  o_fall;
  logic [N_CH-1:0]  o_sw_toggle;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  sw_debounce_sync #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_sw        (i_sw),
    .i_db_th     (i_db_th),
    .o_sw_level  (o_sw_level),
    .o_rise      (o_rise),
    .o_fall      (o_fall),
    .o_sw_toggle (o_sw_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic [3:0] lvl, input logic [3:0] rise,
                                     input logic [3:0] fall, input logic [3:0] tog);
    return {lvl, rise, fall, tog};
  endfunction

  task automatic push(input string tag, input int n, input logic [15:0] val);
    for (int i = 0; i < n; i++) exp_q.push_back('{tag, val});
  endtask

  // One clock per queued expectation; outputs sampled 1 ns after the rising edge.
  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      obs = {o_sw_level, o_rise, o_fall, o_sw_toggle};
      n_cmp++;
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed lvl/rise/fall/tog=%h required %h", e.tag, obs, e.val);
      end
      n_cmp++;
      assert ((o_rise & o_fall) === 4'h0) else begin
        n_bad++;
        $error("FAIL %s_excl: observed rise&fall=%h required 0", e.tag, o_rise & o_fall);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    i_sw    = '0;
    i_db_th = CNT_W'(4);

    push("reset", 3, pk(4'h0, 4'h0, 4'h0, 4'h0));
    drain();

    // Channel 0 press with threshold 4: level at edge 6.
    reset = 1'b0;
    i_sw  = 4'b0001;
    push("ch0_wait", 5, pk(4'h0, 4'h0, 4'h0, 4'h0));
    push("ch0_rise", 1, pk(4'h1, 4'h1, 4'h0, 4'h1));
    push("ch0_hold", 3, pk(4'h1, 4'h0, 4'h0, 4'h1));
    drain();

    // Channel 1 glitch of 3 cycles is rejected.
    i_sw = 4'b0011;
    push("ch1_glitch", 3, pk(4'h1, 4'h0, 4'h0, 4'h1));
    drain();
    i_sw = 4'b0001;
    push("ch1_after", 8, pk(4'h1, 4'h0, 4'h0, 4'h1));
    drain();

    // Channel 2 press/release/press with threshold 2: latency 4.
    i_db_th = CNT_W'(2);
    i_sw    = 4'b0101;
    push("ch2_p1_wait", 3, pk(4'b0001, 4'h0, 4'h0, 4'b0001));
    push("ch2_p1_rise", 1, pk(4'b0101, 4'b0100, 4'h0, 4'b0101));
    push("ch2_p1_hold", 6, pk(4'b0101, 4'h0, 4'h0, 4'b0101));
    drain();
    i_sw = 4'b0001;
    push("ch2_r_wait", 3, pk(4'b0101, 4'h0, 4'h0, 4'b0101));
    push("ch2_fall",   1, pk(4'b0001, 4'h0, 4'b0100, 4'b0101));
    push("ch2_r_hold", 6, pk(4'b0001, 4'h0, 4'h0, 4'b0101));
    drain();
    i_sw = 4'b0101;
    push("ch2_p2_wait", 3, pk(4'b0001, 4'h0, 4'h0, 4'b0101));
    push("ch2_p2_rise", 1, pk(4'b0101, 4'b0100, 4'h0, 4'b0001));
    push("ch2_p2_hold", 6, pk(4'b0101, 4'h0, 4'h0, 4'b0001));
    drain();

    // Threshold 0 behaves as 1: level at edge 3.
    i_db_th = '0;
    i_sw    = 4'b1101;
    push("ch3_wait", 2, pk(4'b0101, 4'h0, 4'h0, 4'b0001));
    push("ch3_rise", 1, pk(4'b1101, 4'b1000, 4'h0, 4'b1001));
    push("ch3_hold", 3, pk(4'b1101, 4'h0, 4'h0, 4'b1001));
    drain();

    // Reset mid-count discards progress; restart takes the full 10 edges.
    reset = 1'b1;
    i_sw  = '0;
    push("rst2", 2, pk(4'h0, 4'h0, 4'h0, 4'h0));
    drain();
    reset   = 1'b0;
    i_db_th = CNT_W'(8);
    i_sw    = 4'hF;
    push("all_pre", 5, pk(4'h0, 4'h0, 4'h0, 4'h0));
    drain();
    reset = 1'b1;
    push("all_rst", 1, pk(4'h0, 4'h0, 4'h0, 4'h0));
    drain();
    reset = 1'b0;
    push("all_wait", 9, pk(4'h0, 4'h0, 4'h0, 4'h0));
    push("all_rise", 1, pk(4'hF, 4'hF, 4'h0, 4'hF));
    push("all_hold", 2, pk(4'hF, 4'h0, 4'h0, 4'hF));
    drain();

    // Lowering the threshold below the running count flips on the next edge.
    reset = 1'b1;
    i_sw  = '0;
    push("rst3", 1, pk(4'h0, 4'h0, 4'h0, 4'h0));
    drain();
    reset   = 1'b0;
    i_db_th = CNT_W'(100);
    i_sw    = 4'b0001;
    push("th100_wait", 49, pk(4'h0, 4'h0, 4'h0, 4'h0));
    drain();
    i_db_th = CNT_W'(10);
    push("th10_rise", 1, pk(4'h1, 4'h1, 4'h0, 4'h1));
    push("th10_hold", 2, pk(4'h1, 4'h0, 4'h0, 4'h1));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
